// File: rtl/delay_tap_if.sv
// Control bundle type and sample/read-port interface for delay_tap.
// Note: the reset field of the control bundle is active-low.
typedef struct packed {
  logic clock;  // single clock, rising edge
  logic reset;  // asynchronous, active-low
} Data_Control_Control_T;

interface delay_tap_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AGE_W = $clog2(DEPTH);

  logic             en;
  logic [WIDTH-1:0] in;
  logic [AGE_W-1:0] age;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [AGE_W:0]   fill;

  modport master (output en, in, age, input out, out_valid, fill);
  modport slave  (input en, in, age, output out, out_valid, fill);
endinterface

// File: rtl/delay_tap.sv
// Random-access history of the last DEPTH samples, read by age (0 = newest).
// Define DELAY_TAP_OUTREG_EN to register out/out_valid (one cycle read latency).
module delay_tap #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input Data_Control_Control_T ctrl,
  delay_tap_if.slave           bus
);
  localparam int AGE_W = $clog2(DEPTH);
  localparam logic [AGE_W:0]   DEPTH_E = (AGE_W+1)'(DEPTH);
  localparam logic [AGE_W-1:0] WP_LAST = AGE_W'(DEPTH-1);

  logic clk;
  logic rst_n;
  assign clk   = ctrl.clock;
  assign rst_n = ctrl.reset;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AGE_W-1:0] wp_reg;
  logic [AGE_W-1:0] wp_next;
  logic [AGE_W:0]   fill_reg;
  logic [AGE_W:0]   fill_next;

  // Explicit wrap keeps non-power-of-two depths correct.
  assign wp_next   = (wp_reg == WP_LAST) ? '0 : wp_reg + 1'b1;
  assign fill_next = (fill_reg == DEPTH_E) ? fill_reg : fill_reg + 1'b1;

  // Storage is cleared asynchronously, so it lives in flops rather than RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wp_reg   <= '0;
      fill_reg <= '0;
    end else if (bus.en) begin
      mem_reg[wp_reg] <= bus.in;
      wp_reg          <= wp_next;
      fill_reg        <= fill_next;
    end
  end

  logic [AGE_W:0]   wp_ext;
  logic [AGE_W:0]   age_ext;
  logic [AGE_W:0]   base;
  logic [AGE_W:0]   idx;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    wp_ext  = {1'b0, wp_reg};
    age_ext = {1'b0, bus.age};
    base    = (wp_reg == '0) ? DEPTH_E - 1'b1 : wp_ext - 1'b1;
    // idx = (wp - 1 - age) mod DEPTH without relying on natural overflow
    if (age_ext > base) begin
      idx = base + DEPTH_E - age_ext;
    end else begin
      idx = base - age_ext;
    end
    rd_valid = (age_ext < fill_reg);
    rd_data  = rd_valid ? mem_reg[idx[AGE_W-1:0]] : '0;
  end

`ifdef DELAY_TAP_OUTREG_EN
  logic [WIDTH-1:0] out_reg;
  logic             out_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_reg       <= rd_data;
      out_valid_reg <= rd_valid;
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
`else
  assign bus.out       = rd_data;
  assign bus.out_valid = rd_valid;
`endif

  assign bus.fill = fill_reg;

endmodule
